// File: rtl/result_transmitter.sv
// result_transmitter: streams a block of 64-bit RAM words to the CPU bus
// as pairs of 32-bit halves (low half first). Each half is offered with INT
// and Bus_OE and held until the CPU acknowledges it.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for Start; bus released
// READ    | RAM address presented for the current word
// LATCH   | RAM data captured into the hold register
// SEND_LO | low half on the bus; INT raised, waiting for CPU_Ack
// SEND_HI | high half on the bus; INT raised, waiting for CPU_Ack
// DONE    | transfer finished; Done_Transmitting pulsed on exit
module result_transmitter #(
    parameter int RAM_ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH        = 64,
    parameter int BUS_WIDTH         = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Start,
    input  logic [RAM_ADDRESS_WIDTH-1:0] Base_Address,
    input  logic [RAM_ADDRESS_WIDTH-1:0] Word_Count,
    output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD_Address,
    input  logic [DATA_WIDTH-1:0]        RAM_RD_Data,
    output logic [BUS_WIDTH-1:0]         Bus_Data,
    output logic                         Bus_OE,
    output logic                         INT,
    input  logic                         CPU_Ack,
    output logic                         Busy,
    output logic                         Done_Transmitting
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_LATCH   = 3'd2,
        S_SEND_LO = 3'd3,
        S_SEND_HI = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [RAM_ADDRESS_WIDTH-1:0] ADDR_ONE = RAM_ADDRESS_WIDTH'(1);
    localparam logic [RAM_ADDRESS_WIDTH-1:0] ADDR_ZERO = '0;

    state_t                         state;
    logic [RAM_ADDRESS_WIDTH-1:0]   addr;
    logic [RAM_ADDRESS_WIDTH-1:0]   remaining;
    logic [DATA_WIDTH-1:0]          hold;
    logic [RAM_ADDRESS_WIDTH-1:0]   ram_addr;
    logic [BUS_WIDTH-1:0]           bus_data;
    logic                           bus_oe;
    logic                           int_r;
    logic                           done;

    // Sequencer and registered outputs. The RAM address is loaded on entry
    // to READ so a one-cycle-latency RAM has data ready by the LATCH edge.
    // INT rises one cycle after a SEND state is entered and drops on the
    // acknowledge edge, so an acknowledge only counts while INT is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            hold      <= '0;
            ram_addr  <= '0;
            bus_data  <= '0;
            bus_oe    <= 1'b0;
            int_r     <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (Start) begin
                        addr      <= Base_Address;
                        remaining <= Word_Count;
                        if (Word_Count != ADDR_ZERO) begin
                            ram_addr <= Base_Address;
                            state    <= S_READ;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    hold  <= RAM_RD_Data;
                    state <= S_SEND_LO;
                end
                S_SEND_LO: begin
                    if (!int_r) begin
                        int_r    <= 1'b1;
                        bus_oe   <= 1'b1;
                        bus_data <= hold[BUS_WIDTH-1:0];
                    end else if (CPU_Ack) begin
                        int_r    <= 1'b0;
                        bus_data <= hold[DATA_WIDTH-1:BUS_WIDTH];
                        state    <= S_SEND_HI;
                    end
                end
                S_SEND_HI: begin
                    if (!int_r) begin
                        int_r <= 1'b1;
                    end else if (CPU_Ack) begin
                        int_r     <= 1'b0;
                        bus_oe    <= 1'b0;
                        bus_data  <= '0;
                        remaining <= remaining - ADDR_ONE;
                        addr      <= addr + ADDR_ONE;
                        if (remaining == ADDR_ONE) begin
                            state <= S_DONE;
                        end else begin
                            ram_addr <= addr + ADDR_ONE;
                            state    <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output wiring; Busy follows the state register directly.
    always_comb begin
        RAM_RD_Address    = ram_addr;
        Bus_Data          = bus_data;
        Bus_OE            = bus_oe;
        INT               = int_r;
        Done_Transmitting = done;
        Busy              = (state != S_IDLE);
    end

endmodule

// File: tb/tb_result_transmitter.sv
// Directed bench for result_transmitter with a one-cycle-latency RAM model.
module tb_result_transmitter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic [12:0] Base_Address = '0;
    logic [12:0] Word_Count = '0;
    logic [12:0] RAM_RD_Address;
    logic [63:0] RAM_RD_Data = '0;
    logic [31:0] Bus_Data;
    logic        Bus_OE;
    logic        INT;
    logic        CPU_Ack = 1'b0;
    logic        Busy;
    logic        Done_Transmitting;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [0:8191];

    result_transmitter dut (
        .CLK               (CLK),
        .RST               (RST),
        .Start             (Start),
        .Base_Address      (Base_Address),
        .Word_Count        (Word_Count),
        .RAM_RD_Address    (RAM_RD_Address),
        .RAM_RD_Data       (RAM_RD_Data),
        .Bus_Data          (Bus_Data),
        .Bus_OE            (Bus_OE),
        .INT               (INT),
        .CPU_Ack           (CPU_Ack),
        .Busy              (Busy),
        .Done_Transmitting (Done_Transmitting)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) RAM_RD_Data <= mem[RAM_RD_Address];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [63:0] words [$];
    logic [12:0] addrs [$];
    logic [12:0] prev_addr;
    logic        prev_int;
    int          dbl_int;
    int          done_cnt;
    int          oe_bad;

    initial begin
        mem[13'h010] = 64'h1122334455667788;
        mem[13'h1FFF] = 64'hA1A2A3A4B1B2B3B4;
        mem[13'h000] = 64'hC1C2C3C4D1D2D3D4;
        mem[13'h001] = 64'hE1E2E3E4F1F2F3F4;
        mem[13'h020] = 64'hDEADBEEFCAFEF00D;
        mem[13'h040] = 64'h0A0B0C0D01020304;

        // Reset state
        step(); step();
        chk("rst_int", 64'(INT), 64'(0));
        chk("rst_oe", 64'(Bus_OE), 64'(0));
        chk("rst_data", 64'(Bus_Data), 64'(0));
        chk("rst_busy", 64'(Busy), 64'(0));
        chk("rst_done", 64'(Done_Transmitting), 64'(0));
        chk("rst_addr", 64'(RAM_RD_Address), 64'(0));
        RST = 1'b0;
        step();
        chk("idle_ack_ignored", 64'(Busy), 64'(0));

        // Single word, ack one cycle after INT
        Base_Address = 13'h010; Word_Count = 13'd1; Start = 1'b1;
        step(); Start = 1'b0;
        chk("a_busy", 64'(Busy), 64'(1));
        chk("a_addr", 64'(RAM_RD_Address), 64'(13'h010));
        chk("a_int_k0", 64'(INT), 64'(0));
        step(); chk("a_int_k1", 64'(INT), 64'(0));
        step(); chk("a_int_k2", 64'(INT), 64'(0));
        step();
        chk("a_int_k3", 64'(INT), 64'(1));
        chk("a_oe_k3", 64'(Bus_OE), 64'(1));
        chk("a_lo", 64'(Bus_Data), 64'(32'h55667788));
        CPU_Ack = 1'b1;
        step();
        chk("a_int_gap", 64'(INT), 64'(0));
        chk("a_oe_gap", 64'(Bus_OE), 64'(1));
        step();
        chk("a_int_hi", 64'(INT), 64'(1));
        chk("a_hi", 64'(Bus_Data), 64'(32'h11223344));
        step();
        CPU_Ack = 1'b0;
        chk("a_int_end", 64'(INT), 64'(0));
        chk("a_oe_end", 64'(Bus_OE), 64'(0));
        chk("a_data_end", 64'(Bus_Data), 64'(0));
        chk("a_done_early", 64'(Done_Transmitting), 64'(0));
        step();
        chk("a_done", 64'(Done_Transmitting), 64'(1));
        chk("a_busy_after", 64'(Busy), 64'(0));
        step();
        chk("a_done_one_cycle", 64'(Done_Transmitting), 64'(0));

        // Zero word count
        Base_Address = 13'h055; Word_Count = 13'd0; Start = 1'b1;
        step(); Start = 1'b0;
        chk("z_busy", 64'(Busy), 64'(1));
        chk("z_done_early", 64'(Done_Transmitting), 64'(0));
        chk("z_int0", 64'(INT), 64'(0));
        step();
        chk("z_done", 64'(Done_Transmitting), 64'(1));
        chk("z_int1", 64'(INT), 64'(0));
        chk("z_oe1", 64'(Bus_OE), 64'(0));
        chk("z_busy_after", 64'(Busy), 64'(0));
        step();
        chk("z_done_one_cycle", 64'(Done_Transmitting), 64'(0));

        // Three words across the address wrap, ack held high throughout
        prev_addr = RAM_RD_Address;
        prev_int = 1'b0; dbl_int = 0; done_cnt = 0; oe_bad = 0;
        Base_Address = 13'h1FFF; Word_Count = 13'd3; CPU_Ack = 1'b1; Start = 1'b1;
        step(); Start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (RAM_RD_Address != prev_addr) addrs.push_back(RAM_RD_Address);
            prev_addr = RAM_RD_Address;
            if (INT) words.push_back(64'(Bus_Data));
            if (INT && prev_int) dbl_int++;
            if (INT && !Bus_OE) oe_bad++;
            prev_int = INT;
            if (Done_Transmitting) done_cnt++;
            step();
        end
        CPU_Ack = 1'b0;
        chk("w_num_words", 64'(words.size()), 64'(6));
        if (words.size() == 6) begin
            chk("w0_lo", words[0], 64'(32'hB1B2B3B4));
            chk("w0_hi", words[1], 64'(32'hA1A2A3A4));
            chk("w1_lo", words[2], 64'(32'hD1D2D3D4));
            chk("w1_hi", words[3], 64'(32'hC1C2C3C4));
            chk("w2_lo", words[4], 64'(32'hF1F2F3F4));
            chk("w2_hi", words[5], 64'(32'hE1E2E3E4));
        end
        chk("w_num_addrs", 64'(addrs.size()), 64'(3));
        if (addrs.size() == 3) begin
            chk("w_addr0", 64'(addrs[0]), 64'(13'h1FFF));
            chk("w_addr1", 64'(addrs[1]), 64'(13'h0000));
            chk("w_addr2", 64'(addrs[2]), 64'(13'h0001));
        end
        chk("w_int_single_cycle", 64'(dbl_int), 64'(0));
        chk("w_int_with_oe", 64'(oe_bad), 64'(0));
        chk("w_done_count", 64'(done_cnt), 64'(1));

        // Ack withheld for 10 cycles; a second Start in that window is ignored
        Base_Address = 13'h020; Word_Count = 13'd1; Start = 1'b1;
        step(); Start = 1'b0;
        step(); step(); step();
        chk("h_int_rise", 64'(INT), 64'(1));
        for (int i = 0; i < 10; i++) begin
            Start = (i == 4);
            if (i == 4) begin
                Base_Address = 13'h030; Word_Count = 13'd5;
            end
            step();
            chk("h_int_stable", 64'(INT), 64'(1));
            chk("h_oe_stable", 64'(Bus_OE), 64'(1));
            chk("h_data_stable", 64'(Bus_Data), 64'(32'hCAFEF00D));
            chk("h_addr_stable", 64'(RAM_RD_Address), 64'(13'h020));
        end
        Start = 1'b0;
        CPU_Ack = 1'b1;
        step();
        chk("h_int_gap", 64'(INT), 64'(0));
        step();
        chk("h_hi", 64'(Bus_Data), 64'(32'hDEADBEEF));
        chk("h_int_hi", 64'(INT), 64'(1));
        step();
        CPU_Ack = 1'b0;
        chk("h_oe_end", 64'(Bus_OE), 64'(0));
        step();
        chk("h_done", 64'(Done_Transmitting), 64'(1));
        chk("h_busy_after", 64'(Busy), 64'(0));
        step();
        step();
        chk("h_second_start_ignored", 64'(Busy), 64'(0));

        // Reset in SEND_HI, then a fresh transfer
        Base_Address = 13'h040; Word_Count = 13'd2; CPU_Ack = 1'b1; Start = 1'b1;
        step(); Start = 1'b0;
        step(); step(); step();
        chk("r_lo", 64'(Bus_Data), 64'(32'h01020304));
        step();
        chk("r_in_send_hi", 64'(Bus_Data), 64'(32'h0A0B0C0D));
        RST = 1'b1;
        step();
        chk("r_int", 64'(INT), 64'(0));
        chk("r_oe", 64'(Bus_OE), 64'(0));
        chk("r_busy", 64'(Busy), 64'(0));
        chk("r_done", 64'(Done_Transmitting), 64'(0));
        chk("r_data", 64'(Bus_Data), 64'(0));
        chk("r_addr", 64'(RAM_RD_Address), 64'(0));
        RST = 1'b0; CPU_Ack = 1'b0;
        step();
        chk("r_no_done", 64'(Done_Transmitting), 64'(0));
        chk("r_idle", 64'(Busy), 64'(0));
        Base_Address = 13'h010; Word_Count = 13'd1; CPU_Ack = 1'b1; Start = 1'b1;
        step(); Start = 1'b0;
        step(); step(); step();
        chk("r2_int", 64'(INT), 64'(1));
        chk("r2_lo", 64'(Bus_Data), 64'(32'h55667788));
        step();
        chk("r2_gap", 64'(INT), 64'(0));
        step();
        chk("r2_hi", 64'(Bus_Data), 64'(32'h11223344));
        step();
        CPU_Ack = 1'b0;
        step();
        chk("r2_done", 64'(Done_Transmitting), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_transmitter.md
RESULT_TRANSMITTER -- requirements
Module: result_transmitter

Interface
REQ-001 Parameter RAM_ADDRESS_WIDTH, default 13, SHALL be the RAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 64, SHALL be the RAM word width.
REQ-003 Parameter BUS_WIDTH, default 32, SHALL be the CPU bus width; DATA_WIDTH = 2*BUS_WIDTH.
REQ-004 CLK  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 RST  input  1  SHALL be a synchronous, active-high reset.
REQ-006 Start  input  1  SHALL be a one-cycle pulse requesting a transfer.
REQ-007 Base_Address  input  RAM_ADDRESS_WIDTH  SHALL be the first RAM word, sampled on Start.
REQ-008 Word_Count  input  RAM_ADDRESS_WIDTH  SHALL be the number of 64-bit words, sampled on Start.
REQ-009 RAM_RD_Address  output  RAM_ADDRESS_WIDTH  SHALL be the RAM read address.
REQ-010 RAM_RD_Data  input  DATA_WIDTH  SHALL be the RAM read data, valid one cycle after the address.
REQ-011 Bus_Data  output  BUS_WIDTH  SHALL be the data driven toward CPU_Bus.
REQ-012 Bus_OE  output  1  SHALL be the tri-state enable for CPU_Bus; the chip top owns the buffer.
REQ-013 INT  output  1  SHALL be high while a valid 32-bit word is on Bus_Data.
REQ-014 CPU_Ack  input  1  SHALL be the CPU acknowledge that the current word is taken.
REQ-015 Busy  output  1  SHALL be high in every state except IDLE.
REQ-016 Done_Transmitting  output  1  SHALL be a one-cycle pulse at transfer end.

Function
REQ-017 States SHALL be IDLE, READ, LATCH, SEND_LO, SEND_HI and DONE.
REQ-018 IDLE: on Start, capture Base_Address into addr and Word_Count into remaining; go to READ if remaining != 0, else go to DONE.
REQ-019 READ: drive RAM_RD_Address = addr; go to LATCH.
REQ-020 LATCH: register RAM_RD_Data into a 64-bit hold register; go to SEND_LO.
REQ-021 SEND_LO: Bus_Data = hold[31:0], Bus_OE=1, INT=1; on CPU_Ack=1 go to SEND_HI.
REQ-022 SEND_HI: Bus_Data = hold[63:32], Bus_OE=1, INT=1; on CPU_Ack=1 decrement remaining and increment addr.
REQ-023 SEND_HI exit: if the decremented remaining is 0, go to DONE; otherwise go to READ.
REQ-024 DONE: pulse Done_Transmitting for exactly one cycle, then go to IDLE.
REQ-025 INT and Bus_OE SHALL hold level in SEND_x until CPU_Ack is sampled high; there is no timeout.
REQ-026 INT SHALL be low for at least one cycle between consecutive words (the SEND_LO to SEND_HI edge registers INT low for one cycle).
REQ-027 CPU_Ack SHALL be ignored in IDLE, READ, LATCH and DONE.
REQ-028 Start SHALL be ignored while Busy=1.
REQ-029 First-word latency: with Start sampled at edge k, INT SHALL first rise at edge k+3.
REQ-030 Address arithmetic SHALL be modulo 2^RAM_ADDRESS_WIDTH; Base_Address 8191 is followed by 0.
REQ-031 Word_Count=0 SHALL produce DONE with no INT and no Bus_OE.
REQ-032 The hold register SHALL be unchanged outside LATCH, so Bus_Data is stable while INT=1.
REQ-033 When Bus_OE=0, Bus_Data SHALL be 0.

Reset
REQ-034 RST=1 at any edge SHALL force IDLE and set INT=0, Bus_OE=0, Bus_Data=0, Busy=0, Done_Transmitting=0, RAM_RD_Address=0, hold=0, remaining=0.
REQ-035 Reset mid-transfer SHALL abandon the transfer without a Done pulse and release the bus in the same cycle.

Verification
REQ-036 Base=0x010, Count=1, RAM[0x010]=0x1122334455667788, Ack one cycle after each INT -> Bus_Data 0x55667788 then 0x11223344, one Done pulse, Busy low afterwards.
REQ-037 Count=3, Base=0x1FFF -> reads 0x1FFF, 0x0000, 0x0001; six INT assertions; the low half always precedes the high half.
REQ-038 Count=0 -> Done pulse 2 cycles after Start; INT and Bus_OE never assert.
REQ-039 Ack held off for 10 cycles in SEND_LO -> INT, Bus_OE and Bus_Data stay stable for all 10 cycles; a second Start in that window is ignored.
REQ-040 RST asserted while in SEND_HI -> the next cycle shows INT=0, Bus_OE=0, Busy=0 and no Done pulse; a new Start then transfers normally.
REQ-041 CPU_Ack held high continuously with Count=2 -> exactly 4 words are transferred, each INT high for one cycle, with no skipped or duplicated half.
